// File: rtl/hex_display_mux_pkg.sv
// Shared definitions for the hex display blocks: seven-segment glyphs,
// the blank pattern and the PWM phase width.
package hex_display_mux_pkg;

  // Segment order inside a glyph is {A,B,C,D,E,F,G}, active-high.
  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bright_t;

  localparam int          PWM_W      = 4;
  localparam bright_t     BRIGHT_MAX = 4'hF;
  localparam logic [7:0]  SEG_OFF    = 8'h00;

  localparam seg7_t SEG7_0 = 7'b1111110;
  localparam seg7_t SEG7_1 = 7'b0110000;
  localparam seg7_t SEG7_2 = 7'b1101101;
  localparam seg7_t SEG7_3 = 7'b1111001;
  localparam seg7_t SEG7_4 = 7'b0110011;
  localparam seg7_t SEG7_5 = 7'b1011011;
  localparam seg7_t SEG7_6 = 7'b1011111;
  localparam seg7_t SEG7_7 = 7'b1110000;
  localparam seg7_t SEG7_8 = 7'b1111111;
  localparam seg7_t SEG7_9 = 7'b1111011;
  localparam seg7_t SEG7_A = 7'b1110111;
  localparam seg7_t SEG7_B = 7'b0011111;
  localparam seg7_t SEG7_C = 7'b1001110;
  localparam seg7_t SEG7_D = 7'b0111101;
  localparam seg7_t SEG7_E = 7'b1001111;
  localparam seg7_t SEG7_F = 7'b1000111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment glyph decoder ({A..G}, active-high).
module hex_to_seg7
  import hex_display_mux_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      pattern_o
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this block purely
    // combinational even if an arm is ever removed; no latch can be inferred.
    pattern_o = '0;
    unique case (nibble_i)
      4'h0: pattern_o = SEG7_0;
      4'h1: pattern_o = SEG7_1;
      4'h2: pattern_o = SEG7_2;
      4'h3: pattern_o = SEG7_3;
      4'h4: pattern_o = SEG7_4;
      4'h5: pattern_o = SEG7_5;
      4'h6: pattern_o = SEG7_6;
      4'h7: pattern_o = SEG7_7;
      4'h8: pattern_o = SEG7_8;
      4'h9: pattern_o = SEG7_9;
      4'hA: pattern_o = SEG7_A;
      4'hB: pattern_o = SEG7_B;
      4'hC: pattern_o = SEG7_C;
      4'hD: pattern_o = SEG7_D;
      4'hE: pattern_o = SEG7_E;
      4'hF: pattern_o = SEG7_F;
    endcase
  end

endmodule

// File: rtl/hex_display_mux.sv
// Multiplexed common-anode hex display driver with decimal points, blanking,
// leading-zero suppression, 16-level PWM brightness and an end-of-frame strobe.
module hex_display_mux
  import hex_display_mux_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int CNT_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_we,
  input  logic [N_DIGITS-1:0]   i_blank,
  input  logic                  i_lzs,
  input  logic [3:0]            i_bright,
  input  logic                  i_cfg_we,
  output logic [N_DIGITS-1:0]   o_anodes,
  output logic [7:0]            o_segments,
  output logic                  o_frame
);

  localparam int                    POS_W    = $clog2(N_DIGITS);
  localparam logic [POS_W-1:0]      POS_LAST = POS_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0]   DIGIT0   = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic [4*N_DIGITS-1:0] data_q,     data_d;
  logic [N_DIGITS-1:0]   dp_q,       dp_d;
  logic [N_DIGITS-1:0]   blank_q,    blank_d;
  logic                  lzs_q,      lzs_d;
  bright_t               bright_q,   bright_d;
  logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [POS_W-1:0]      pos_q,      pos_d;
  logic [N_DIGITS-1:0]   anodes_q,   anodes_d;
  logic [7:0]            segments_q, segments_d;
  logic                  frame_q,    frame_d;

  logic [N_DIGITS-1:0]   suppress;
  logic [3:0]            cur_nibble;
  seg7_t                 cur_pattern;
  logic [PWM_W-1:0]      phase;
  logic                  slot_end;
  logic                  pwm_on;
  logic                  dark;

  always_comb begin
    data_d   = data_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    lzs_d    = lzs_q;
    bright_d = bright_q;
    if (i_we) begin
      data_d = i_data;
      dp_d   = i_dp;
    end
    if (i_cfg_we) begin
      blank_d  = i_blank;
      lzs_d    = i_lzs;
      bright_d = i_bright;
    end
  end

  // Free-running prescaler; the digit position steps on its all-ones value.
  assign slot_end = &cnt_q;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    pos_d   = pos_q;
    frame_d = 1'b0;
    if (slot_end) begin
      if (pos_q == POS_LAST) begin
        pos_d   = '0;
        frame_d = 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  // Prefix-OR from the most significant digit down: a digit is a leading zero
  // when it and everything above it are zero. Digit 0 always shows.
  always_comb begin : lzs_mask
    logic seen;
    seen     = 1'b0;
    suppress = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      seen        = seen | (|data_q[4*k +: 4]);
      suppress[k] = lzs_q & (k != 0) & ~seen;
    end
  end

  assign cur_nibble = data_q[{pos_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i  (cur_nibble),
    .pattern_o (cur_pattern)
  );

  assign phase  = cnt_q[CNT_WIDTH-1 -: PWM_W];
  assign pwm_on = (phase <= bright_q);
  assign dark   = blank_q[pos_q] | suppress[pos_q] | ~pwm_on;

  always_comb begin
    anodes_d   = '1;
    segments_d = SEG_OFF;
    if (!dark) begin
      anodes_d   = ~(DIGIT0 << pos_q);
      segments_d = {cur_pattern, dp_q[pos_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data buffer is a few flops rather than a RAM, so it is
      // cleared with the rest of the state; the display reads all zeros.
      data_q     <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      lzs_q      <= 1'b0;
      bright_q   <= BRIGHT_MAX;
      cnt_q      <= '0;
      pos_q      <= '0;
      anodes_q   <= '1;
      segments_q <= SEG_OFF;
      frame_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      data_q     <= data_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      lzs_q      <= lzs_d;
      bright_q   <= bright_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
      frame_q    <= frame_d;
    end
  end

  assign o_anodes   = anodes_q;
  assign o_segments = segments_q;
  assign o_frame    = frame_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux (4 digits, 64-cycle slot): vector table, hand-written
// timing sequences and randomized traffic against a cycle-count reference model.
module tb_hex_display_mux;

  localparam int N  = 4;
  localparam int CW = 6;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   i_data;
  logic [3:0]    i_dp, i_blank, i_bright;
  logic          i_we, i_lzs, i_cfg_we;
  logic [3:0]    o_anodes;
  logic [7:0]    o_segments;
  logic          o_frame;

  int n_vec = 0;
  int n_err = 0;

  hex_display_mux #(.N_DIGITS(N), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (i_data),
    .i_dp       (i_dp),
    .i_we       (i_we),
    .i_blank    (i_blank),
    .i_lzs      (i_lzs),
    .i_bright   (i_bright),
    .i_cfg_we   (i_cfg_we),
    .o_anodes   (o_anodes),
    .o_segments (o_segments),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the display is a pure function of cycles since reset
  // (t) and the buffered data/config; outputs show the state one cycle back.
  bit          model_on = 1'b0;
  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank, m_bright;
  logic        m_lzs;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fr;
  int          r_pos, r_phase;
  logic [15:0] r_upper;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_on = 1'b1;
      m_t = 0; m_data = '0; m_dp = '0; m_blank = '0; m_lzs = 1'b0; m_bright = 4'hF;
      e_an = 4'hF; e_seg = 8'h00; e_fr = 1'b0;
    end else if (model_on) begin
      r_pos   = (m_t / 64) % 4;
      r_phase = (m_t % 64) / 4;
      r_upper = m_data >> (4 * r_pos);
      if (m_blank[r_pos] || (m_lzs && r_pos > 0 && r_upper == 0) || r_phase > int'(m_bright)) begin
        e_an  = 4'hF;
        e_seg = 8'h00;
      end else begin
        e_an  = 4'hF & ~(4'b0001 << r_pos);
        e_seg = {SEG_REF[r_upper[3:0]], m_dp[r_pos]};
      end
      e_fr = (m_t % 256) == 255;
      if (i_we) begin
        m_data = i_data;
        m_dp   = i_dp;
      end
      if (i_cfg_we) begin
        m_blank  = i_blank;
        m_lzs    = i_lzs;
        m_bright = i_bright;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model", {o_anodes, o_segments, o_frame}, {e_an, e_seg, e_fr});
      check("one_anode_low", 32'($countones(~o_anodes) <= 1), 32'd1);
    end
  end

  typedef struct {
    string      name;
    logic [15:0] data;
    logic [3:0]  dp, blank;
    logic        lzs;
    logic [3:0]  bright;
    int          k, c;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
  } vec_t;

  function automatic vec_t mk(string n, logic [15:0] d, logic [3:0] dp, logic [3:0] bl,
                              logic lz, logic [3:0] br, int k, int c,
                              logic [3:0] an, logic [7:0] sg);
    vec_t v;
    v.name = n; v.data = d; v.dp = dp; v.blank = bl; v.lzs = lz; v.bright = br;
    v.k = k; v.c = c; v.exp_an = an; v.exp_seg = sg;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_we = 1'b0; i_cfg_we = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // After this the outputs show t=0 (old buffer); t>=1 shows the new values.
  task automatic setup(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                       input logic lz, input logic [3:0] br);
    do_reset();
    i_data = d; i_dp = dp; i_blank = bl; i_lzs = lz; i_bright = br;
    i_we = 1'b1; i_cfg_we = 1'b1;
    step(1);
    i_we = 1'b0; i_cfg_we = 1'b0;
  endtask

  vec_t vecs[$];
  int   cnt, first, second;

  initial begin
    rst_n = 1'b0; i_data = '0; i_dp = '0; i_we = 1'b0; i_blank = '0;
    i_lzs = 1'b0; i_bright = 4'hF; i_cfg_we = 1'b0;

    // Reset state, then digit 0 is the first lit slot.
    step(1);
    check("reset_outputs", {o_anodes, o_segments, o_frame}, {4'hF, 8'h00, 1'b0});
    rst_n = 1'b1;
    step(1);
    check("first_slot_digit0", {o_anodes, o_segments}, {4'b1110, 8'hFC});

    vecs.push_back(mk("f_d0",      16'h12AF, 4'b0000, 4'b0000, 0, 15, 0,  8, 4'b1110, 8'h8E));
    vecs.push_back(mk("a_d1",      16'h12AF, 4'b0000, 4'b0000, 0, 15, 1,  8, 4'b1101, 8'hEE));
    vecs.push_back(mk("2_d2",      16'h12AF, 4'b0000, 4'b0000, 0, 15, 2,  8, 4'b1011, 8'hDA));
    vecs.push_back(mk("1_d3",      16'h12AF, 4'b0000, 4'b0000, 0, 15, 3,  8, 4'b0111, 8'h60));
    vecs.push_back(mk("1_d3_last", 16'h12AF, 4'b0000, 4'b0000, 0, 15, 3, 63, 4'b0111, 8'h60));
    vecs.push_back(mk("lzs_d3",    16'h0030, 4'b0000, 4'b0000, 1, 15, 3,  8, 4'b1111, 8'h00));
    vecs.push_back(mk("lzs_d2",    16'h0030, 4'b0000, 4'b0000, 1, 15, 2,  8, 4'b1111, 8'h00));
    vecs.push_back(mk("lzs_d1",    16'h0030, 4'b0000, 4'b0000, 1, 15, 1,  8, 4'b1101, 8'hF2));
    vecs.push_back(mk("lzs_d0",    16'h0030, 4'b0000, 4'b0000, 1, 15, 0,  8, 4'b1110, 8'hFC));
    vecs.push_back(mk("lzs0_d0",   16'h0000, 4'b0000, 4'b0000, 1, 15, 0,  8, 4'b1110, 8'hFC));
    vecs.push_back(mk("lzs0_d1",   16'h0000, 4'b0000, 4'b0000, 1, 15, 1,  8, 4'b1111, 8'h00));
    vecs.push_back(mk("nolzs_d3",  16'h0000, 4'b0000, 4'b0000, 0, 15, 3,  8, 4'b0111, 8'hFC));
    vecs.push_back(mk("inner0_d3", 16'h0100, 4'b0000, 4'b0000, 1, 15, 3,  8, 4'b1111, 8'h00));
    vecs.push_back(mk("inner0_d2", 16'h0100, 4'b0000, 4'b0000, 1, 15, 2,  8, 4'b1011, 8'h60));
    vecs.push_back(mk("inner0_d1", 16'h0100, 4'b0000, 4'b0000, 1, 15, 1,  8, 4'b1101, 8'hFC));
    vecs.push_back(mk("dp_d2",     16'h12AF, 4'b0100, 4'b0001, 0, 15, 2,  8, 4'b1011, 8'hDB));
    vecs.push_back(mk("blank_d0",  16'h12AF, 4'b0100, 4'b0001, 0, 15, 0,  8, 4'b1111, 8'h00));
    vecs.push_back(mk("blank_d1",  16'h12AF, 4'b0100, 4'b0001, 0, 15, 1,  8, 4'b1101, 8'hEE));
    vecs.push_back(mk("blank_dp",  16'h12AF, 4'b0001, 4'b0001, 0, 15, 0,  8, 4'b1111, 8'h00));
    vecs.push_back(mk("br3_on",    16'h12AF, 4'b0000, 4'b0000, 0,  3, 1, 15, 4'b1101, 8'hEE));
    vecs.push_back(mk("br3_off",   16'h12AF, 4'b0000, 4'b0000, 0,  3, 1, 16, 4'b1111, 8'h00));
    vecs.push_back(mk("br0_on",    16'h12AF, 4'b0000, 4'b0000, 0,  0, 2,  3, 4'b1011, 8'hDA));
    vecs.push_back(mk("br0_off",   16'h12AF, 4'b0000, 4'b0000, 0,  0, 2,  4, 4'b1111, 8'h00));
    vecs.push_back(mk("seg_7",     16'h4567, 4'b0000, 4'b0000, 0, 15, 0,  1, 4'b1110, 8'hE0));
    vecs.push_back(mk("seg_6",     16'h4567, 4'b0000, 4'b0000, 0, 15, 1,  1, 4'b1101, 8'hBE));
    vecs.push_back(mk("seg_5",     16'h4567, 4'b0000, 4'b0000, 0, 15, 2,  1, 4'b1011, 8'hB6));
    vecs.push_back(mk("seg_4",     16'h4567, 4'b0000, 4'b0000, 0, 15, 3,  1, 4'b0111, 8'h66));
    vecs.push_back(mk("seg_c",     16'h89BC, 4'b0000, 4'b0000, 0, 15, 0, 30, 4'b1110, 8'h9C));
    vecs.push_back(mk("seg_b",     16'h89BC, 4'b0000, 4'b0000, 0, 15, 1, 30, 4'b1101, 8'h3E));
    vecs.push_back(mk("seg_9",     16'h89BC, 4'b0000, 4'b0000, 0, 15, 2, 30, 4'b1011, 8'hF6));
    vecs.push_back(mk("seg_8",     16'h89BC, 4'b0000, 4'b0000, 0, 15, 3, 30, 4'b0111, 8'hFE));
    vecs.push_back(mk("seg_d",     16'hDE00, 4'b0000, 4'b0000, 0, 15, 3, 40, 4'b0111, 8'h7A));
    vecs.push_back(mk("seg_e",     16'hDE00, 4'b0000, 4'b0000, 0, 15, 2, 40, 4'b1011, 8'h9E));

    foreach (vecs[i]) begin
      setup(vecs[i].data, vecs[i].dp, vecs[i].blank, vecs[i].lzs, vecs[i].bright);
      step(64 * vecs[i].k + vecs[i].c);
      check(vecs[i].name, {o_anodes, o_segments}, {vecs[i].exp_an, vecs[i].exp_seg});
    end

    // Frame strobe: one pulse every 256 cycles.
    setup(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'hF);
    cnt = 0; first = -1; second = -1;
    for (int i = 1; i <= 1024; i++) begin
      step(1);
      if (o_frame) begin
        if (cnt == 0) first = i;
        else if (cnt == 1) second = i;
        cnt++;
      end
    end
    check("frame_count", cnt, 4);
    check("frame_first", first, 255);
    check("frame_spacing", second - first, 256);

    // PWM duty over a whole slot.
    setup(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'd3);
    cnt = 0;
    for (int i = 1; i <= 256; i++) begin
      step(1);
      if (o_anodes == 4'b1101) cnt++;
    end
    check("pwm_bright3", cnt, 16);
    setup(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'd0);
    cnt = 0;
    for (int i = 1; i <= 256; i++) begin
      step(1);
      if (o_anodes == 4'b1101) cnt++;
    end
    check("pwm_bright0", cnt, 4);

    // Write latency: visible one edge after the writing edge.
    setup(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'hF);
    step(8);
    i_data = 16'h12A5; i_we = 1'b1;
    step(1);
    i_we = 1'b0;
    check("wr_old_at_edge", o_segments, 8'h8E);
    step(1);
    check("wr_new_next", o_segments, 8'hB6);
    i_blank = 4'b0001; i_cfg_we = 1'b1;
    step(1);
    i_cfg_we = 1'b0;
    check("cfg_old_at_edge", o_anodes, 4'b1110);
    step(1);
    check("cfg_new_next", o_anodes, 4'b1111);
    i_blank = 4'b0000;

    // Mid-scan reset restarts at digit 0 with a cleared buffer and a full slot.
    setup(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'hF);
    step(160);
    check("pre_reset_d2", o_anodes, 4'b1011);
    rst_n = 1'b0;
    step(1);
    check("midreset_off", {o_anodes, o_segments, o_frame}, {4'hF, 8'h00, 1'b0});
    rst_n = 1'b1;
    step(1);
    check("midreset_d0", {o_anodes, o_segments}, {4'b1110, 8'hFC});
    cnt = 1;
    for (int i = 1; i < 64; i++) begin
      step(1);
      if (o_anodes == 4'b1110) cnt++;
    end
    check("midreset_slot_len", cnt, 64);
    step(1);
    check("midreset_next_d1", o_anodes, 4'b1101);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      i_we = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++)
        i_data[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
      i_dp = 4'($urandom_range(0, 15));
      i_cfg_we = ($urandom_range(0, 15) == 0);
      i_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      i_lzs = 1'($urandom_range(0, 1));
      i_bright = 4'($urandom_range(0, 15));
      step(1);
    end
    rst_n = 1'b1; i_we = 1'b0; i_cfg_we = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
